// File: rtl/cache_controller_if.sv
// CPU, data-RAM and memory-side signal bundle for cache_controller.
// slave: the controller's view. master: the environment's view (CPU, RAM, memory).
interface cache_controller_if #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned INDEX_WIDTH       = 7,
  parameter int unsigned WORD_OFFSET_WIDTH = 2
);
  // CPU side
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_we;
  logic [ADDR_WIDTH-1:0]        req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic                         resp_valid;
  logic [DATA_WIDTH-1:0]        resp_rdata;
  // Data RAM side
  logic [INDEX_WIDTH-1:0]       ram_index;
  logic [WORD_OFFSET_WIDTH-1:0] ram_offset;
  logic [DATA_WIDTH-1:0]        ram_wdata;
  logic                         ram_we;
  logic [DATA_WIDTH-1:0]        ram_rdata;
  // Memory side
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic                         mem_req_we;
  logic [ADDR_WIDTH-1:0]        mem_req_addr;
  logic [DATA_WIDTH-1:0]        mem_req_wdata;
  logic                         mem_rvalid;
  logic [DATA_WIDTH-1:0]        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
           mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, ram_index, ram_offset, ram_wdata, ram_we,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
           mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, ram_index, ram_offset, ram_wdata, ram_we,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Tags and valid bits are internal; line data lives in an external RAM with
// a registered (1-cycle) read port. Define CACHE_STATS_EN to add the
// saturating stat_hits / stat_misses counters.
module cache_controller #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CACHE_LINES       = 128,
  parameter int unsigned WORD_NUM          = 4,
  parameter int unsigned INDEX_WIDTH       = 7,
  parameter int unsigned WORD_OFFSET_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH        = 32,
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_controller_if.slave       bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int unsigned LineLsb = WORD_OFFSET_WIDTH + 2;
  localparam int unsigned TagLsb  = LineLsb + INDEX_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLookup, StRefillReq, StRefill, StRespond, StWrMem
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic                         we_q;
  logic [DATA_WIDTH-1:0]        wdata_q;
  logic [WORD_OFFSET_WIDTH-1:0] beat_q, beat_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic [CACHE_LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]         tag_mem [CACHE_LINES];

  logic [INDEX_WIDTH-1:0]       idx;
  logic [WORD_OFFSET_WIDTH-1:0] off;
  logic [TAG_WIDTH-1:0]         tag;
  logic                         hit;
  logic                         accept;
  logic                         line_fill;

  assign idx    = addr_q[TagLsb-1:LineLsb];
  assign off    = addr_q[LineLsb-1:2];
  assign tag    = addr_q[ADDR_WIDTH-1:TagLsb];
  assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
  assign accept = (state_q == StIdle) && bus.req_valid;

  // State, request capture, beat counter and response data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Valid bits; a line only becomes valid once its last refill beat lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (line_fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag array, no reset needed since valid bits gate every use
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_mem[idx] <= tag;
    end
  end

  // Next-state and all bus outputs
  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    rdata_d           = rdata_q;
    line_fill         = 1'b0;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = rdata_q;
    bus.ram_index     = idx;
    bus.ram_offset    = off;
    bus.ram_wdata     = wdata_q;
    bus.ram_we        = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = addr_q;
    bus.mem_req_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        bus.req_ready  = 1'b1;
        // Present the address now so RAM data is ready in LOOKUP
        bus.ram_index  = bus.req_addr[TagLsb-1:LineLsb];
        bus.ram_offset = bus.req_addr[LineLsb-1:2];
        if (bus.req_valid) state_d = StLookup;
      end
      StLookup: begin
        if (we_q) begin
          bus.ram_we = hit;
          state_d    = StWrMem;
        end else if (hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = bus.ram_rdata;
          rdata_d        = bus.ram_rdata;
          state_d        = StIdle;
        end else begin
          state_d = StRefillReq;
        end
      end
      StRefillReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {addr_q[ADDR_WIDTH-1:LineLsb], {LineLsb{1'b0}}};
        if (bus.mem_req_ready) state_d = StRefill;
      end
      StRefill: begin
        bus.ram_offset = beat_q;
        bus.ram_wdata  = bus.mem_rdata;
        if (bus.mem_rvalid) begin
          bus.ram_we = 1'b1;
          beat_d     = beat_q + 1'b1;
          if (beat_q == off) rdata_d = bus.mem_rdata;
          if (beat_q == WORD_OFFSET_WIDTH'(WORD_NUM - 1)) begin
            line_fill = 1'b1;
            beat_d    = '0;
            state_d   = StRespond;
          end
        end
      end
      StRespond: begin
        bus.resp_valid = 1'b1;
        state_d        = StIdle;
      end
      StWrMem: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        if (bus.mem_req_ready) begin
          bus.resp_valid = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  // Saturating hit/miss counters, one event per LOOKUP cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state_q == StLookup) begin
      if (hit && hits_q != '1) hits_q <= hits_q + 1'b1;
      if (!hit && misses_q != '1) misses_q <= misses_q + 1'b1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a registered data-RAM model plus a
// hand-driven memory side; expected values are computed by hand below.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   mem_hs = 0;

  always #5 clk = ~clk;

  cache_controller_if bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  cache_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // Data RAM model: 128 lines x 4 words, registered read port
  logic [31:0] ram [512];
  always @(posedge clk) begin
    if (bus.ram_we) ram[{bus.ram_index, bus.ram_offset}] <= bus.ram_wdata;
    bus.ram_rdata <= ram[{bus.ram_index, bus.ram_offset}];
  end

  // Memory-request handshakes seen
  always @(posedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) mem_hs <= mem_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_mem_req_we", 32'(bus.mem_req_we), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_stat_hits", stat_hits, 32'd0);
    chk("rst_stat_misses", stat_misses, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Read miss at 0x10: line refill A0..A3, returns A0
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10;
    #1;
    chk("rd10_accept_index", 32'(bus.ram_index), 32'd1);
    chk("rd10_accept_offset", 32'(bus.ram_offset), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd10_lookup_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rd10_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("rd10_mreq_we", 32'(bus.mem_req_we), 32'd0);
    chk("rd10_mreq_addr", bus.mem_req_addr, 32'h10);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rd10_mreq_addr_held", bus.mem_req_addr, 32'h10);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA0 + 32'(i);
      #1;
      chk("rd10_beat_we", 32'(bus.ram_we), 32'd1);
      chk("rd10_beat_offset", 32'(bus.ram_offset), 32'(i));
      chk("rd10_beat_wdata", bus.ram_wdata, 32'hA0 + 32'(i));
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    #1;
    chk("rd10_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd10_resp_rdata", bus.resp_rdata, 32'hA0);
    chk("rd10_resp_ram_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    #1;
    chk("rd10_back_idle", 32'(bus.req_ready), 32'd1);
    chk("rd10_resp_single", 32'(bus.resp_valid), 32'd0);
    chk("rd10_one_line_read", 32'(mem_hs), 32'd1);

    // Read hit at 0x14: response in the cycle after accept
    bus.req_valid = 1'b1; bus.req_addr = 32'h14;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd14_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd14_resp_rdata", bus.resp_rdata, 32'hA1);
    chk("rd14_no_mreq", 32'(bus.mem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rd14_resp_single", 32'(bus.resp_valid), 32'd0);

    // Write hit at 0x18, memory stalls 3 cycles
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h18; bus.req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    #1;
    chk("wr18_ram_we", 32'(bus.ram_we), 32'd1);
    chk("wr18_ram_index", 32'(bus.ram_index), 32'd1);
    chk("wr18_ram_offset", 32'(bus.ram_offset), 32'd2);
    chk("wr18_ram_wdata", bus.ram_wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("wr18_stall_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("wr18_stall_mreq_we", 32'(bus.mem_req_we), 32'd1);
      chk("wr18_stall_mreq_addr", bus.mem_req_addr, 32'h18);
      chk("wr18_stall_mreq_wdata", bus.mem_req_wdata, 32'hDEADBEEF);
      chk("wr18_stall_no_resp", 32'(bus.resp_valid), 32'd0);
      chk("wr18_stall_ram_we", 32'(bus.ram_we), 32'd0);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("wr18_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("wr18_resp_rdata_kept", bus.resp_rdata, 32'hA1);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    chk("wr18_back_idle", 32'(bus.req_ready), 32'd1);
    chk("wr18_resp_single", 32'(bus.resp_valid), 32'd0);

    // Write miss at 0x0001_0010 (same index, other tag): memory only
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0001_0010;
    bus.req_wdata = 32'h1234_5678;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    #1;
    chk("wrmiss_ram_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("wrmiss_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("wrmiss_mreq_we", 32'(bus.mem_req_we), 32'd1);
    chk("wrmiss_mreq_addr", bus.mem_req_addr, 32'h0001_0010);
    chk("wrmiss_mreq_wdata", bus.mem_req_wdata, 32'h1234_5678);
    chk("wrmiss_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("wrmiss_ram_we_wr", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
`ifdef CACHE_STATS_EN
    // Lookups so far: miss 0x10, hit 0x14, hit 0x18 (write), miss 0x10010 (write)
    chk("stat_hits", stat_hits, 32'd2);
    chk("stat_misses", stat_misses, 32'd2);
`endif

    // Read 0x18 now hits with the stored word
    bus.req_valid = 1'b1; bus.req_addr = 32'h18;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd18_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd18_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;

    // Read 0x10 still hits after the write miss to the same index
    bus.req_valid = 1'b1; bus.req_addr = 32'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd10b_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd10b_resp_rdata", bus.resp_rdata, 32'hA0);
    chk("rd10b_no_mreq", 32'(bus.mem_req_valid), 32'd0);
    @(negedge clk);
    #1;

    // Read 0x24 misses; reset during the second refill beat
    bus.req_valid = 1'b1; bus.req_addr = 32'h24;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd24_miss", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rd24_mreq_addr", bus.mem_req_addr, 32'h20);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC0;
    #1;
    chk("rd24_beat0_we", 32'(bus.ram_we), 32'd1);
    @(negedge clk);
    bus.mem_rdata = 32'hC1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_idle", 32'(bus.req_ready), 32'd1);
    chk("rstmid_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rstmid_mreq_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rstmid_resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b0;
    #1;
    chk("rstmid_stays_idle", 32'(bus.req_ready), 32'd1);

    // Same line again must miss and refill fully
    bus.req_valid = 1'b1; bus.req_addr = 32'h24;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("rd24b_miss", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1;
    chk("rd24b_mreq_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("rd24b_mreq_addr", bus.mem_req_addr, 32'h20);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hC0 + 32'(i);
      #1;
      chk("rd24b_beat_offset", 32'(bus.ram_offset), 32'(i));
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    #1;
    chk("rd24b_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd24b_resp_rdata", bus.resp_rdata, 32'hC1);
`ifdef CACHE_STATS_EN
    chk("stat_hits_after_rst", stat_hits, 32'd0);
    chk("stat_misses_after_rst", stat_misses, 32'd1);
`endif
    @(negedge clk);
    #1;
    chk("rd24b_back_idle", 32'(bus.req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
